// File: rtl/flush_ctrl_pkg.sv
// Shared constants for the WB flush/redirect controller: ecodes and FSM states.
package flush_ctrl_pkg;

    localparam logic [5:0] ECODE_INT          = 6'h00;
    localparam logic [5:0] ECODE_SYS          = 6'h0B;
    localparam logic [5:0] ECODE_ERTN_DEFAULT = 6'h00;
    localparam logic [5:0] ECODE_TLBR_DEFAULT = 6'h3F;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_REDIR = 1'b1
    } fc_state_t;

endpackage

// File: rtl/flush_ctrl_sat_cnt.sv
// Saturating up-counter: adds one per inc pulse and sticks at all-ones.
module sat_cnt #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt
);

    // Count accepted events, holding at the maximum value
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/flush_ctrl.sv
// WB flush controller: kills pre-WB stages on exception/ertn/refetch and
// holds a registered redirect toward fetch until fetch accepts it.
module flush_ctrl
    import flush_ctrl_pkg::*;
#(
    parameter logic [5:0]  ECODE_TLBR = ECODE_TLBR_DEFAULT,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             wb_ex,
    input  logic             ertn_flush,
    input  logic             wb_refetch_flush,
    input  logic [5:0]       wb_ecode,
    input  logic [31:0]      wb_pc,
    input  logic [31:0]      csr_eentry,
    input  logic [31:0]      csr_tlbrentry,
    input  logic [31:0]      csr_era,
    input  logic             fs_redirect_ready,
    output logic             flush_all,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic             busy,
    output logic [CNT_W-1:0] ex_cnt,
    output logic [CNT_W-1:0] ertn_cnt,
    output logic [CNT_W-1:0] refetch_cnt
);

    fc_state_t   state;
    logic        event_any;
    logic        ex_win;
    logic        ertn_win;
    logic        refetch_win;
    logic [31:0] target;

    assign event_any   = wb_ex | ertn_flush | wb_refetch_flush;
    assign flush_all   = event_any;
    assign ex_win      = wb_ex;
    assign ertn_win    = ertn_flush & ~wb_ex;
    assign refetch_win = wb_refetch_flush & ~wb_ex & ~ertn_flush;
    assign busy        = (state == ST_REDIR);

    // Priority target mux: exception, then ertn, then refetch
    always_comb begin
        target = wb_pc + 32'd4;
        if (wb_ex) begin
            target = (wb_ecode == ECODE_TLBR) ? csr_tlbrentry : csr_eentry;
        end else if (ertn_flush) begin
            target = csr_era;
        end
    end

    // Redirect FSM: latest event wins, hold until fetch accepts
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state          <= ST_IDLE;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (event_any) begin
                        state          <= ST_REDIR;
                        redirect_valid <= 1'b1;
                        redirect_pc    <= target;
                    end
                end
                ST_REDIR: begin
                    if (event_any) begin
                        redirect_pc <= target;
                    end else if (fs_redirect_ready) begin
                        state          <= ST_IDLE;
                        redirect_valid <= 1'b0;
                    end
                end
                default: begin
                    state          <= ST_IDLE;
                    redirect_valid <= 1'b0;
                end
            endcase
        end
    end

    sat_cnt #(.WIDTH(CNT_W)) u_ex_cnt (
        .clk    (clk),
        .resetn (resetn),
        .inc    (ex_win),
        .cnt    (ex_cnt)
    );

    sat_cnt #(.WIDTH(CNT_W)) u_ertn_cnt (
        .clk    (clk),
        .resetn (resetn),
        .inc    (ertn_win),
        .cnt    (ertn_cnt)
    );

    sat_cnt #(.WIDTH(CNT_W)) u_refetch_cnt (
        .clk    (clk),
        .resetn (resetn),
        .inc    (refetch_win),
        .cnt    (refetch_cnt)
    );

endmodule
